iterative_shift_unit: RTL and testbench

Multi-cycle shifter for the MIPS datapath that executes SLL, SRL, SRA and rotate-right one bit position per clock. It handles the right-shifting direction the fixed address-alignment shifters do not cover. It sits beside the ALU, takes the operand and shift amount on a start pulse, and returns the result with a done pulse. Area stays small: one register, a 1-bit shift stage and a down-counter replace a full barrel shifter.

---
 rtl/iterative_shift_unit_if.sv | 23 ++
 rtl/iterative_shift_unit.sv | 111 +++++++++++
 tb/tb_iterative_shift_unit.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/iterative_shift_unit_if.sv
// Request/response bundle between the datapath and the iterative shifter.
interface iterative_shift_unit_if #(
  parameter int WIDTH       = 32,
  parameter int SHAMT_WIDTH = 5
) ();
  logic                   start;
  logic [1:0]             op;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic [WIDTH-1:0]       data_in;
  logic                   busy;
  logic                   done;
  logic [WIDTH-1:0]       result;

  modport master (
    output start, op, shamt, data_in,
    input  busy, done, result
  );

  modport slave (
    input  start, op, shamt, data_in,
    output busy, done, result
  );
endinterface

// File: rtl/iterative_shift_unit.sv
// Multi-cycle shifter: SLL/SRL/SRA/ROR, one bit position per clock.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | waiting for start; operands latched on start
// S_SHIFT | one-bit shift per cycle while the down-counter runs out
// S_DONE  | single-cycle done pulse; result already registered
module iterative_shift_unit #(
  parameter int WIDTH       = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  iterative_shift_unit_if.slave bus
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       work_q, work_d;
  logic [SHAMT_WIDTH-1:0] count_q, count_d;
  logic [1:0]             op_q, op_d;
  logic [WIDTH-1:0]       result_q, result_d;
  logic                   done_q, done_d;
  logic [WIDTH-1:0]       shifted;

  // One-bit shift stage applied to the work register.
  always_comb begin
    shifted = work_q;
    case (op_q)
      OP_SLL:  shifted = {work_q[WIDTH-2:0], 1'b0};
      OP_SRL:  shifted = {1'b0, work_q[WIDTH-1:1]};
      OP_SRA:  shifted = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      default: shifted = {work_q[0], work_q[WIDTH-1:1]};
    endcase
  end

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    count_d  = count_q;
    op_d     = op_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          work_d  = bus.data_in;
          count_d = bus.shamt;
          op_d    = bus.op;
          if (bus.shamt == '0) begin
            // Zero shift: result is the operand itself, straight to DONE.
            state_d  = S_DONE;
            result_d = bus.data_in;
            done_d   = 1'b1;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        work_d  = shifted;
        count_d = count_q - 1'b1;
        if (count_q == SHAMT_WIDTH'(1)) begin
          state_d  = S_DONE;
          result_d = shifted;
          done_d   = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      work_q   <= '0;
      count_q  <= '0;
      op_q     <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      count_q  <= count_d;
      op_q     <= op_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_iterative_shift_unit.sv
// Directed self-checking bench for iterative_shift_unit.
module tb_iterative_shift_unit;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  iterative_shift_unit_if #(.WIDTH(32), .SHAMT_WIDTH(5)) bus ();

  iterative_shift_unit #(.WIDTH(32), .SHAMT_WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Caller is at a negedge; request is seen at the next posedge (E0).
  // Returns at the negedge after E0 (index 1).
  task automatic do_start(input logic [1:0] o, input logic [4:0] s, input logic [31:0] d);
    bus.op      = o;
    bus.shamt   = s;
    bus.data_in = d;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start   = 1'b0;
  endtask

  // Walks negedges from index idx0 until busy falls; records first done.
  task automatic wait_done(input int idx0, output int done_idx, output logic [31:0] res,
                           output int busy_n, output int pulses);
    int idx;
    idx      = idx0;
    done_idx = -1;
    res      = '0;
    busy_n   = 0;
    pulses   = 0;
    while (idx <= 200) begin
      if (bus.done) begin
        pulses++;
        if (done_idx < 0) begin
          done_idx = idx;
          res      = bus.result;
        end
      end
      if (!bus.busy) break;
      busy_n++;
      @(negedge clk);
      idx++;
    end
    if (idx > 200) begin
      checks++;
      failures++;
      $display("FAIL wait_timeout: busy still %0b after %0d cycles, required 0", bus.busy, idx);
    end
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.op      = 2'b00;
    bus.shamt   = '0;
    bus.data_in = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
    checks++;
    if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b want 0", bus.done); end
    checks++;
    if (bus.result !== 32'h0) begin failures++; $display("FAIL reset_result: got %h want 00000000", bus.result); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sll();
    int di, bn, pn;
    logic [31:0] r;
    do_start(2'b00, 5'd4, 32'h0000_0001);
    wait_done(1, di, r, bn, pn);
    checks++;
    if (r !== 32'h0000_0010) begin failures++; $display("FAIL sll_result: got %h want 00000010", r); end
    checks++;
    if (di !== 5) begin failures++; $display("FAIL sll_done_cycle: got %0d want 5 (4 edges after start edge)", di); end
    checks++;
    if (bn !== 5) begin failures++; $display("FAIL sll_busy_cycles: got %0d want 5", bn); end
    checks++;
    if (pn !== 1) begin failures++; $display("FAIL sll_done_pulses: got %0d want 1", pn); end
  endtask

  task automatic test_sra_srl();
    int di, bn, pn;
    logic [31:0] r;
    do_start(2'b10, 5'd31, 32'h8000_0000);
    wait_done(1, di, r, bn, pn);
    checks++;
    if (r !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sra_result: got %h want ffffffff", r); end
    checks++;
    if (di !== 32) begin failures++; $display("FAIL sra_done_cycle: got %0d want 32", di); end
    do_start(2'b01, 5'd31, 32'h8000_0000);
    wait_done(1, di, r, bn, pn);
    checks++;
    if (r !== 32'h0000_0001) begin failures++; $display("FAIL srl_result: got %h want 00000001", r); end
    do_start(2'b10, 5'd4, 32'h4000_0000);
    wait_done(1, di, r, bn, pn);
    checks++;
    if (r !== 32'h0400_0000) begin failures++; $display("FAIL sra_pos_result: got %h want 04000000", r); end
  endtask

  task automatic test_ror_zero();
    int di, bn, pn;
    logic [31:0] r;
    do_start(2'b11, 5'd1, 32'h0000_0001);
    wait_done(1, di, r, bn, pn);
    checks++;
    if (r !== 32'h8000_0000) begin failures++; $display("FAIL ror1_result: got %h want 80000000", r); end
    checks++;
    if (di !== 2) begin failures++; $display("FAIL ror1_done_cycle: got %0d want 2", di); end
    do_start(2'b11, 5'd8, 32'h1234_5678);
    wait_done(1, di, r, bn, pn);
    checks++;
    if (r !== 32'h7812_3456) begin failures++; $display("FAIL ror8_result: got %h want 78123456", r); end
    do_start(2'b00, 5'd0, 32'hDEAD_BEEF);
    wait_done(1, di, r, bn, pn);
    checks++;
    if (r !== 32'hDEAD_BEEF) begin failures++; $display("FAIL zero_result: got %h want deadbeef", r); end
    checks++;
    if (di !== 1) begin failures++; $display("FAIL zero_done_cycle: got %0d want 1", di); end
    checks++;
    if (bn !== 1) begin failures++; $display("FAIL zero_busy_cycles: got %0d want 1", bn); end
  endtask

  task automatic test_back_to_back();
    int di, bn, pn;
    logic [31:0] r;
    do_start(2'b00, 5'd8, 32'h0000_0001);
    // Now at index 1 (SHIFT): fire a conflicting request for one cycle.
    bus.op      = 2'b11;
    bus.shamt   = 5'd1;
    bus.data_in = 32'hFFFF_FFFF;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start   = 1'b0;
    wait_done(2, di, r, bn, pn);
    checks++;
    if (r !== 32'h0000_0100) begin failures++; $display("FAIL busy_ignore_result: got %h want 00000100", r); end
    checks++;
    if (di !== 9) begin failures++; $display("FAIL busy_ignore_done_cycle: got %0d want 9", di); end
    checks++;
    if (pn !== 1) begin failures++; $display("FAIL busy_ignore_pulses: got %0d want 1", pn); end
    // Current negedge is the IDLE cycle right after done.
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL b2b_idle_busy: got %0b want 0", bus.busy); end
    do_start(2'b01, 5'd4, 32'h0000_0100);
    checks++;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL b2b_accept_busy: got %0b want 1", bus.busy); end
    wait_done(1, di, r, bn, pn);
    checks++;
    if (r !== 32'h0000_0010) begin failures++; $display("FAIL b2b_result: got %h want 00000010", r); end
    checks++;
    if (di !== 5) begin failures++; $display("FAIL b2b_done_cycle: got %0d want 5", di); end
  endtask

  task automatic test_reset_mid_op();
    int pn, bn;
    do_start(2'b01, 5'd20, 32'hF000_0000);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %0b want 0", bus.busy); end
    checks++;
    if (bus.done !== 1'b0) begin failures++; $display("FAIL midrst_done: got %0b want 0", bus.done); end
    checks++;
    if (bus.result !== 32'h0) begin failures++; $display("FAIL midrst_result: got %h want 00000000", bus.result); end
    rst = 1'b0;
    pn = 0;
    bn = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.done) pn++;
      if (bus.busy) bn++;
    end
    checks++;
    if (pn !== 0) begin failures++; $display("FAIL midrst_no_done: got %0d pulses want 0", pn); end
    checks++;
    if (bn !== 0) begin failures++; $display("FAIL midrst_no_busy: got %0d busy cycles want 0", bn); end
  endtask

  task automatic test_result_hold();
    int di, bn, pn, bad;
    logic [31:0] r, seen;
    do_start(2'b00, 5'd4, 32'h0000_0001);
    wait_done(1, di, r, bn, pn);
    checks++;
    if (r !== 32'h0000_0010) begin failures++; $display("FAIL hold_setup_result: got %h want 00000010", r); end
    do_start(2'b00, 5'd16, 32'h0000_0003);
    bad  = 0;
    seen = 32'h0000_0010;
    for (int i = 1; i < 17; i++) begin
      if (bus.result !== 32'h0000_0010) begin bad++; seen = bus.result; end
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL hold_stable: result %h during shift, want 00000010", seen); end
    checks++;
    if (bus.done !== 1'b1) begin failures++; $display("FAIL hold_done_cycle: done %0b at index 17 want 1", bus.done); end
    checks++;
    if (bus.result !== 32'h0003_0000) begin failures++; $display("FAIL hold_new_result: got %h want 00030000", bus.result); end
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_sll();
    test_sra_srl();
    test_ror_zero();
    test_back_to_back();
    test_reset_mid_op();
    test_result_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
